// File: rtl/multicycle_main_control.sv
// rtl/multicycle_main_control.sv - multicycle RV32I main control FSM with memory handshake and retire counter
module multicycle_main_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic [1:0]       ALUop,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             PCSource,
    output logic             RegWrite,
    output logic             MemtoReg,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state_dbg
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic             r_illegal;
    logic [CNT_W-1:0] r_retired;
    logic             w_retire;
    logic             w_illegal;

    always_comb begin
        w_next    = S_FETCH;
        w_illegal = 1'b0;
        case (r_state)
            S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: w_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   w_next = S_ALUWB;
            S_ALUWB:  w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            default:  w_next = S_FETCH;
        endcase
    end

    assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) ||
                      (r_state == S_BRANCH) || ((r_state == S_MEMWR) && mem_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_illegal) begin
                r_illegal <= 1'b1;
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    // Moore decode; reset gating keeps every request low the instant rst_n falls.
    always_comb begin
        ALUop       = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 1'b0;
        RegWrite    = 1'b0;
        MemtoReg    = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_DECODE: ALUSrcB = 2'b11;
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUop   = 2'b10;
                end
                S_ALUWB: RegWrite = 1'b1;
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUop       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign illegal_op = r_illegal;
    assign retired    = r_retired;
    assign state_dbg  = r_state;

endmodule

// File: tb/tb_multicycle_main_control.sv
// tb/tb_multicycle_main_control.sv - randomized self-checking bench for multicycle_main_control
module tb_multicycle_main_control;

    logic        clk;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        mem_ready;

    logic [1:0]  ALUop, ALUSrcB;
    logic        ALUSrcA, IorD, MemRead, MemWrite, IRWrite, PCWrite;
    logic        PCWriteCond, PCSource, RegWrite, MemtoReg, illegal_op;
    logic [31:0] retired;
    logic [3:0]  state_dbg;

    logic [1:0]  n_ALUop, n_ALUSrcB;
    logic        n_ALUSrcA, n_IorD, n_MemRead, n_MemWrite, n_IRWrite, n_PCWrite;
    logic        n_PCWriteCond, n_PCSource, n_RegWrite, n_MemtoReg, n_illegal_op;
    logic [3:0]  n_retired;
    logic [3:0]  n_state_dbg;

    logic [14:0] obs;
    assign obs = {ALUop, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
                  PCWrite, PCWriteCond, PCSource, RegWrite, MemtoReg};

    int          checks;
    int          failures;
    int unsigned n_ret;
    bit          ill;

    multicycle_main_control #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .ALUop(ALUop), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCWriteCond(PCWriteCond), .PCSource(PCSource), .RegWrite(RegWrite),
        .MemtoReg(MemtoReg), .illegal_op(illegal_op), .retired(retired),
        .state_dbg(state_dbg)
    );

    multicycle_main_control #(.CNT_W(4)) dut_narrow (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .ALUop(n_ALUop), .ALUSrcA(n_ALUSrcA), .ALUSrcB(n_ALUSrcB), .IorD(n_IorD),
        .MemRead(n_MemRead), .MemWrite(n_MemWrite), .IRWrite(n_IRWrite), .PCWrite(n_PCWrite),
        .PCWriteCond(n_PCWriteCond), .PCSource(n_PCSource), .RegWrite(n_RegWrite),
        .MemtoReg(n_MemtoReg), .illegal_op(n_illegal_op), .retired(n_retired),
        .state_dbg(n_state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Control word required in each named phase, written straight from the phase table.
    function automatic logic [14:0] exp_ctrl(input int st, input bit rdy);
        logic [1:0] aluop, srcb;
        logic srca, iord, mrd, mwr, irw, pcw, pcwc, pcsrc, rw, m2r;
        aluop = 2'b00; srcb = 2'b00; srca = 0; iord = 0; mrd = 0; mwr = 0;
        irw = 0; pcw = 0; pcwc = 0; pcsrc = 0; rw = 0; m2r = 0;
        case (st)
            0: begin mrd = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
            1: srcb = 2'b11;
            2: begin srca = 1; srcb = 2'b10; end
            3: begin mrd = 1; iord = 1; end
            4: begin rw = 1; m2r = 1; end
            5: begin mwr = 1; iord = 1; end
            6: begin srca = 1; aluop = 2'b10; end
            7: rw = 1;
            8: begin srca = 1; aluop = 2'b01; pcwc = 1; pcsrc = 1; end
            default: ;
        endcase
        return {aluop, srca, srcb, iord, mrd, mwr, irw, pcw, pcwc, pcsrc, rw, m2r};
    endfunction

    function automatic bit is_legal(input logic [6:0] op);
        return op == 7'b0110011 || op == 7'b0000011 || op == 7'b0100011 || op == 7'b1100011;
    endfunction

    // One clock: drive mem_ready, check after settling, advance to the next falling edge.
    task automatic step(input int st, input bit rdy);
        mem_ready = rdy;
        #1;
        chk("state", 32'(state_dbg), 32'(st));
        chk("ctrl", 32'(obs), 32'(exp_ctrl(st, rdy)));
        chk("retired", retired, n_ret);
        chk("illegal_op", 32'(illegal_op), 32'(ill));
        chk("retired_w4", 32'(n_retired), n_ret % 16);
        chk("state_w4", 32'(n_state_dbg), 32'(st));
        @(negedge clk);
    endtask

    task automatic run_instr(input logic [6:0] op, input int fw, input int mw);
        opcode = op;
        for (int i = 0; i < fw; i++) step(0, 1'b0);
        step(0, 1'b1);
        step(1, 1'($urandom % 2));
        if (!is_legal(op)) ill = 1'b1;
        case (op)
            7'b0110011: begin step(6, 1'($urandom % 2)); step(7, 1'($urandom % 2)); end
            7'b0000011: begin
                step(2, 1'($urandom % 2));
                for (int i = 0; i < mw; i++) step(3, 1'b0);
                step(3, 1'b1);
                step(4, 1'($urandom % 2));
            end
            7'b0100011: begin
                step(2, 1'($urandom % 2));
                for (int i = 0; i < mw; i++) step(5, 1'b0);
                step(5, 1'b1);
            end
            7'b1100011: step(8, 1'($urandom % 2));
            default: ;
        endcase
        if (is_legal(op)) n_ret++;
    endtask

    task automatic check_reset_state();
        chk("rst_enables", 32'({IRWrite, PCWrite, PCWriteCond, RegWrite, MemWrite, MemRead}), 32'h0);
        chk("rst_state", 32'(state_dbg), 32'h0);
        chk("rst_retired", retired, 32'h0);
        chk("rst_illegal", 32'(illegal_op), 32'h0);
        chk("rst_retired_w4", 32'(n_retired), 32'h0);
    endtask

    initial begin
        logic [6:0] op;
        checks = 0; failures = 0; n_ret = 0; ill = 1'b0;
        rst_n = 1'b0; opcode = 7'b0110011; mem_ready = 1'b1;
        #2;
        check_reset_state();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_instr(7'b0110011, 0, 0);
        run_instr(7'b0000011, 0, 2);
        run_instr(7'b0100011, 3, 0);
        run_instr(7'b1100011, 0, 0);
        run_instr(7'b1111111, 0, 0);
        run_instr(7'b0110011, 0, 0);

        // Abort a store while it waits on memory.
        opcode = 7'b0100011;
        step(0, 1'b1);
        step(1, 1'b0);
        step(2, 1'b0);
        step(5, 1'b0);
        mem_ready = 1'b0;
        #1;
        chk("memwr_before_rst", 32'(MemWrite), 32'h1);
        rst_n = 1'b0;
        #1;
        check_reset_state();
        n_ret = 0; ill = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 16; k++) run_instr(7'b0110011, 0, 0);
        chk("wrap_w4", 32'(n_retired), 32'h0);
        chk("count_16", retired, 32'd16);

        for (int k = 0; k < 60; k++) begin
            case ($urandom % 5)
                0: op = 7'b0110011;
                1: op = 7'b0000011;
                2: op = 7'b0100011;
                3: op = 7'b1100011;
                default: begin
                    op = 7'($urandom);
                    while (is_legal(op)) op = 7'($urandom);
                end
            endcase
            run_instr(op, int'($urandom % 3), int'($urandom % 3));
        end
        step(0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Main control FSM for the multicycle RV32I core. It produces ALUop and all datapath enables per instruction phase, feeding the existing ALU decode stage.
- Covers R-type (0110011), LW (0000011), SW (0100011) and BEQ (1100011), with a ready handshake to unified memory and a retired-instruction counter.
- Sits between the instruction register opcode field and the datapath muxes and enables.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  7  instruction bits [6:0] from IR
mem_ready  input  1  memory completes the current MemRead/MemWrite this cycle
ALUop  output  2  00 add, 01 subtract, 10 decode by funct fields
ALUSrcA  output  1  0 = PC of current instruction, 1 = rs1 register
ALUSrcB  output  2  00 rs2, 01 constant 4, 10 load/store imm, 11 branch imm
IorD  output  1  memory address: 0 = PC, 1 = ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  load IR
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load if ALU zero
PCSource  output  1  0 = ALU result, 1 = ALUOut
RegWrite  output  1  register file write
MemtoReg  output  1  writeback: 0 = ALUOut, 1 = MDR
illegal_op  output  1  sticky: unsupported opcode decoded
retired  output  CNT_W  instructions completed since reset
state_dbg  output  4  current state encoding

Behaviour:
- Reset: clk and rst_n per the already-decided rule — one clock; reset is asynchronous and active-low.
- While rst_n=0: state = FETCH, illegal_op=0, retired=0, all write enables (IRWrite, PCWrite, PCWriteCond, RegWrite, MemWrite) forced 0, MemRead=0.
- The first FETCH cycle begins on the first rising clk edge after rst_n deasserts.
- Outputs are Moore, decoded from state. Exception: IRWrite and PCWrite in FETCH are gated by mem_ready.
- Any control output not listed for a state is 0.
- State encodings and transitions:
  - FETCH=0: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=0. If mem_ready=1, assert IRWrite=1 and PCWrite=1, then go to DECODE. Otherwise stay in FETCH.
  - DECODE=1: ALUSrcA=0, ALUSrcB=11, ALUop=00 (branch target into ALUOut).
    - LW or SW → MEMADR.
    - R-type → EXEC.
    - BEQ → BRANCH.
    - Any other opcode → FETCH, set illegal_op, retired unchanged.
  - MEMADR=2: ALUSrcA=1, ALUSrcB=10, ALUop=00. LW → MEMRD, SW → MEMWR. opcode is held stable by IR.
  - MEMRD=3: MemRead=1, IorD=1. Go to MEMWB on mem_ready; otherwise stay.
  - MEMWB=4: RegWrite=1, MemtoReg=1 → FETCH.
  - MEMWR=5: MemWrite=1, IorD=1. Go to FETCH on mem_ready; otherwise stay. MemWrite stays high for every wait cycle.
  - EXEC=6: ALUSrcA=1, ALUSrcB=00, ALUop=10 → ALUWB.
  - ALUWB=7: RegWrite=1, MemtoReg=0 → FETCH.
  - BRANCH=8: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=1 → FETCH.
- Encodings 9–15 are unreachable. If entered, go to FETCH next cycle with all enables 0.
- Cycle counts with zero wait states:
  - R-type: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ: 3 cycles.
  - Each memory wait cycle adds 1.
- retired increments by 1 on the edge leaving MEMWB, MEMWR (with mem_ready), ALUWB or BRANCH. It wraps modulo 2^CNT_W with no saturation.
- illegal_op clears only on reset.
- If rst_n asserts mid-instruction, it aborts immediately: no further enables, the partial instruction is not counted.
- mem_ready in a non-memory state is ignored.

Test Plan:
- Reset then R-type (opcode 0110011), mem_ready=1 always → states 0,1,6,7,0. ALUop=10 in EXEC. RegWrite=1 exactly one cycle in ALUWB. retired=1.
- LW (0000011) with mem_ready low for 2 cycles in MEMRD → MemRead held 3 cycles with IorD=1. MEMWB has RegWrite=1, MemtoReg=1. Total 7 cycles; retired increments once.
- SW (0100011), FETCH stalled 3 cycles → IRWrite/PCWrite stay 0 until the mem_ready cycle, then pulse once. MemWrite=1 in MEMWR only. RegWrite never 1.
- BEQ (1100011) → BRANCH has ALUop=01, PCWriteCond=1, PCSource=1. Sequence 0,1,8,0.
- Illegal opcode 1111111 → DECODE→FETCH, illegal_op=1 and stays 1 across the next valid R-type. retired unchanged by the illegal one.
- rst_n pulsed low asynchronously mid-MEMWR with mem_ready=0 → MemWrite drops without a clock. state_dbg=0, retired=0, illegal_op=0. Restart fetches normally. Also CNT_W=4 with 16 R-types → retired wraps to 0.
